alt_aeq_ch_scheduler: RTL and testbench
=======================================

ALT_AEQ_CH_SCHEDULER -- requirements
Module: alt_aeq_ch_scheduler

Interface
REQ-001 The block SHALL have parameter N_CH, default 5: number of transceiver channels served.
REQ-002 The block SHALL have parameter N_SEL, default 3: logical channel select width, with 2^N_SEL >= N_CH.
REQ-003 The block SHALL have parameter SETTLE_CYC, default 4: mux settle cycles after a channel select change, minimum 1.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1000: maximum cycles spent waiting for adaptation done.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port i_enable, input, 1 bit: permits new channel grants.
REQ-008 The block SHALL have port i_ch_req, input, N_CH bits: per-channel recalibration request pulses.
REQ-009 The block SHALL have port o_logical_ch, output, N_SEL bits: channel select driven to the channel muxes.
REQ-010 The block SHALL have port o_ch_start, output, 1 bit: one-cycle adaptation start for the selected channel.
REQ-011 The block SHALL have port i_ch_adce_done, input, 1 bit: muxed adaptation-done flag of the selected channel.
REQ-012 The block SHALL have port i_ch_testbus, input, 7 bits: muxed testbus of the selected channel.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have ports o_result (7 bits), o_result_ch (N_SEL bits) and o_result_valid (1 bit), all outputs: the captured testbus, its channel, and a one-cycle valid.
REQ-015 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse when adaptation times out.

Function
REQ-016 The block SHALL OR i_ch_req into a pending[N_CH] register every cycle; pending SHALL become visible one cycle after the request.
REQ-017 The block SHALL use an FSM with states IDLE, SETTLE, START, WAIT and CAPTURE.
REQ-018 In IDLE, when i_enable=1 and pending!=0, the block SHALL select the first set pending bit at or after rr_ptr, wrapping modulo N_CH, load o_logical_ch with it, and go to SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYC cycles and then go to START.
REQ-020 START SHALL last one cycle, during which o_ch_start=1 and pending[ch] is cleared; the FSM SHALL then go to WAIT with the timer cleared.
REQ-021 If i_ch_req[ch] is set in the same cycle that pending[ch] is cleared, the set SHALL win.
REQ-022 In WAIT, i_ch_adce_done=1 SHALL move the FSM to CAPTURE.
REQ-023 In WAIT, if TIMEOUT_CYC cycles elapse without done, the block SHALL pulse o_timeout for one cycle, set rr_ptr=(ch+1) mod N_CH, and go to IDLE with no result produced.
REQ-024 If done arrives in the same cycle the timeout expires, done SHALL win.
REQ-025 In CAPTURE, o_result SHALL register i_ch_testbus and o_result_ch SHALL register ch.
REQ-026 o_result_valid SHALL be 1 in the cycle after CAPTURE.
REQ-027 On leaving CAPTURE, the block SHALL set rr_ptr=(ch+1) mod N_CH and go to IDLE.
REQ-028 o_result and o_result_ch SHALL hold their values until the next capture.
REQ-029 o_logical_ch SHALL be stable from SETTLE through CAPTURE.
REQ-030 i_ch_adce_done SHALL be ignored outside WAIT.
REQ-031 i_enable=0 SHALL block only new grants; an in-flight channel SHALL complete.
REQ-032 Timing from an idle block: i_ch_req pulse in cycle 0 -> o_logical_ch valid in cycle 2 -> o_ch_start in cycle 2+SETTLE_CYC.

Reset
REQ-033 When i_rst=1 at a clock edge, the block SHALL set state=IDLE, pending=0, rr_ptr=0, o_logical_ch=0, o_ch_start=0, o_busy=0, o_result=0, o_result_ch=0, o_result_valid=0 and o_timeout=0.
REQ-034 Reset in any state, including mid-WAIT, SHALL abort the operation with no o_result_valid or o_timeout pulse.

Structure
REQ-035 The FSM state enumeration and the default parameter constants SHALL be placed in the shared package alt_aeq_sched_pkg.
REQ-036 The round-robin first-set-bit search SHALL be the single combinational sub-module alt_aeq_rr_pick (inputs: pending, rr_ptr; outputs: index, any).
REQ-037 The timer SHALL be $clog2(TIMEOUT_CYC+1) bits wide, and the settle counter $clog2(SETTLE_CYC+1) bits wide.

Verification
REQ-038 Single request: i_ch_req=5'b00100 in cycle 0 with the block idle -> o_logical_ch=2 in cycle 2, o_ch_start in cycle 6; done asserted with testbus 7'h2A -> o_result=7'h2A, o_result_ch=2, one o_result_valid pulse.
REQ-039 Fairness: i_ch_req=5'b11111 with done returned after 3 cycles -> channels serviced in order 0,1,2,3,4, then rr_ptr=0.
REQ-040 Timeout: channel 3 requested and done never asserted -> o_timeout pulses exactly TIMEOUT_CYC cycles after START, no o_result_valid, and the next grant starts from channel 4.
REQ-041 Re-request: i_ch_req[1] pulsed during channel 1's START cycle -> channel 1 serviced a second time.
REQ-042 Reset mid-WAIT: i_rst=1 during channel 0's WAIT -> all outputs 0 the next cycle, pending=0, and a later done is ignored.
REQ-043 Enable and done boundaries: i_enable=0 with pending=5'b00001 -> no o_ch_start; done and timeout coinciding -> o_result_valid only, no o_timeout.

Source files
------------

// File: rtl/alt_aeq_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : alt_aeq_sched_pkg                                            |
// | Desc   : Shared types and default constants for the AEQ channel       |
// |          scheduler and its round-robin picker.                        |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package alt_aeq_sched_pkg;

   localparam int c_DEF_N_CH        = 5;
   localparam int c_DEF_N_SEL       = 3;
   localparam int c_DEF_SETTLE_CYC  = 4;
   localparam int c_DEF_TIMEOUT_CYC = 1000;
   localparam int c_TESTBUS_W       = 7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_START   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_CAPTURE = 3'd4
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/alt_aeq_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : alt_aeq_rr_pick                                              |
// | Desc   : Combinational round-robin search: first set pending bit at   |
// |          or after the pointer, wrapping to the lowest set bit.        |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module alt_aeq_rr_pick
   import alt_aeq_sched_pkg::*;
#(
   parameter int N_CH  = c_DEF_N_CH,
   parameter int N_SEL = c_DEF_N_SEL
) (
   input  logic [N_CH-1:0]  i_pending,
   input  logic [N_SEL-1:0] i_rr_ptr,
   output logic [N_SEL-1:0] o_index,
   output logic             o_any
);

   logic [N_SEL-1:0] w_hi_idx;
   logic [N_SEL-1:0] w_lo_idx;
   logic             w_hi_any;
   logic             w_lo_any;

   // Descending scan so the lowest qualifying channel is the last write;
   // "hi" restricts to channels at/after the pointer, "lo" is the wrap case.
   always_comb begin
      w_hi_idx = '0;
      w_lo_idx = '0;
      w_hi_any = 1'b0;
      w_lo_any = 1'b0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (i_pending[c]) begin
            w_lo_idx = N_SEL'(c);
            w_lo_any = 1'b1;
            if (c >= int'(i_rr_ptr)) begin
               w_hi_idx = N_SEL'(c);
               w_hi_any = 1'b1;
            end
         end
      end
   end

   assign o_index = w_hi_any ? w_hi_idx : w_lo_idx;
   assign o_any   = w_lo_any;

endmodule
`default_nettype wire

// File: rtl/alt_aeq_ch_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : alt_aeq_ch_scheduler                                         |
// | Desc   : Round-robin scheduler sharing one adaptation engine across   |
// |          N_CH transceiver channels: select, settle, start, wait for   |
// |          done (with timeout) and capture the channel testbus.         |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module alt_aeq_ch_scheduler
   import alt_aeq_sched_pkg::*;
#(
   parameter int N_CH        = c_DEF_N_CH,
   parameter int N_SEL       = c_DEF_N_SEL,
   parameter int SETTLE_CYC  = c_DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = c_DEF_TIMEOUT_CYC
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic [N_CH-1:0]        i_ch_req,
   output logic [N_SEL-1:0]       o_logical_ch,
   output logic                   o_ch_start,
   input  logic                   i_ch_adce_done,
   input  logic [c_TESTBUS_W-1:0] i_ch_testbus,
   output logic                   o_busy,
   output logic [c_TESTBUS_W-1:0] o_result,
   output logic [N_SEL-1:0]       o_result_ch,
   output logic                   o_result_valid,
   output logic                   o_timeout
);

   localparam int c_TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int c_SET_W = $clog2(SETTLE_CYC + 1);
   localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);
   localparam logic [N_SEL-1:0]   c_LAST_CH  = N_SEL'(N_CH - 1);

   sched_state_t             r_state;
   sched_state_t             w_state_nxt;
   logic [N_CH-1:0]          r_pending;
   logic [N_CH-1:0]          w_clr_mask;
   logic [N_SEL-1:0]         r_rr_ptr;
   logic [N_SEL-1:0]         r_logical_ch;
   logic [N_SEL-1:0]         w_pick_idx;
   logic [N_SEL-1:0]         w_next_ptr;
   logic                     w_pick_any;
   logic                     w_grant;
   logic                     w_timeout;
   logic                     w_release;
   logic [c_TMR_W-1:0]       r_timer;
   logic [c_SET_W-1:0]       r_settle_cnt;
   logic [c_TESTBUS_W-1:0]   r_result;
   logic [N_SEL-1:0]         r_result_ch;
   logic                     r_result_valid;

   alt_aeq_rr_pick #(
      .N_CH  (N_CH),
      .N_SEL (N_SEL)
   ) u_rr_pick (
      .i_pending (r_pending),
      .i_rr_ptr  (r_rr_ptr),
      .o_index   (w_pick_idx),
      .o_any     (w_pick_any)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode; done takes priority over an expiring timer.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_enable && w_pick_any) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_settle_cnt == c_SET_LAST) w_state_nxt = ST_START;
         end
         ST_START: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (i_ch_adce_done) begin
               w_state_nxt = ST_CAPTURE;
            end else if (r_timer == c_TMR_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CAPTURE: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_clr_mask = (r_state == ST_START) ? (N_CH'(1) << r_logical_ch) : '0;
   assign w_release  = w_timeout || (r_state == ST_CAPTURE);
   assign w_next_ptr = (r_logical_ch == c_LAST_CH) ? '0 : r_logical_ch + N_SEL'(1);

   // Pending requests: new request bits override the clear of the started channel.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_pending <= '0;
      else       r_pending <= (r_pending & ~w_clr_mask) | i_ch_req;
   end

   // Channel select, settle counter, wait timer and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_logical_ch <= '0;
         r_settle_cnt <= '0;
         r_timer      <= '0;
         r_rr_ptr     <= '0;
      end else begin
         if (w_grant) begin
            r_logical_ch <= w_pick_idx;
            r_settle_cnt <= '0;
         end
         if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
         if (r_state == ST_START)  r_timer      <= '0;
         if (r_state == ST_WAIT)   r_timer      <= r_timer + c_TMR_W'(1);
         if (w_release)            r_rr_ptr     <= w_next_ptr;
      end
   end

   // Result capture; valid pulses in the cycle following CAPTURE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_result       <= '0;
         r_result_ch    <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (r_state == ST_CAPTURE) begin
            r_result       <= i_ch_testbus;
            r_result_ch    <= r_logical_ch;
            r_result_valid <= 1'b1;
         end
      end
   end

   assign o_logical_ch   = r_logical_ch;
   assign o_ch_start     = (r_state == ST_START);
   assign o_busy         = (r_state != ST_IDLE);
   assign o_result       = r_result;
   assign o_result_ch    = r_result_ch;
   assign o_result_valid = r_result_valid;
   // Timeout pulses in the last WAIT cycle; a reset in that cycle suppresses it.
   assign o_timeout      = w_timeout && !i_rst;

endmodule
`default_nettype wire

// File: tb/tb_alt_aeq_ch_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module : tb_alt_aeq_ch_scheduler                                      |
// | Desc   : Directed self-checking bench for alt_aeq_ch_scheduler.       |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_alt_aeq_ch_scheduler;

   localparam int c_N_CH   = 5;
   localparam int c_N_SEL  = 3;
   localparam int c_SETTLE = 4;
   localparam int c_TMO    = 20;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_enable = 1'b1;
   logic [c_N_CH-1:0]  i_ch_req = '0;
   logic [c_N_SEL-1:0] o_logical_ch;
   logic               o_ch_start;
   logic               i_ch_adce_done = 1'b0;
   logic [6:0]         i_ch_testbus = '0;
   logic               o_busy;
   logic [6:0]         o_result;
   logic [c_N_SEL-1:0] o_result_ch;
   logic               o_result_valid;
   logic               o_timeout;

   int n_cmp = 0;
   int n_err = 0;

   alt_aeq_ch_scheduler #(
      .N_CH        (c_N_CH),
      .N_SEL       (c_N_SEL),
      .SETTLE_CYC  (c_SETTLE),
      .TIMEOUT_CYC (c_TMO)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_enable       (i_enable),
      .i_ch_req       (i_ch_req),
      .o_logical_ch   (o_logical_ch),
      .o_ch_start     (o_ch_start),
      .i_ch_adce_done (i_ch_adce_done),
      .i_ch_testbus   (i_ch_testbus),
      .o_busy         (o_busy),
      .o_result       (o_result),
      .o_result_ch    (o_result_ch),
      .o_result_valid (o_result_valid),
      .o_timeout      (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Advance until o_ch_start is seen (returns in the START cycle).
   task automatic wait_start(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         if (o_ch_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // From START: wait dly cycles, give done for one cycle; returns in the valid cycle.
   task automatic finish_ch(input int dly, input logic [6:0] tb);
      repeat (dly) tick();
      i_ch_adce_done = 1'b1;
      i_ch_testbus   = tb;
      tick();
      i_ch_adce_done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (o_logical_ch !== 3'd0) begin n_err++; $display("FAIL reset_logical_ch: got %0d want 0", o_logical_ch); end
      n_cmp++; if (o_ch_start !== 1'b0) begin n_err++; $display("FAIL reset_ch_start: got %b want 0", o_ch_start); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_cmp++; if (o_result !== 7'h00) begin n_err++; $display("FAIL reset_result: got %h want 00", o_result); end
      n_cmp++; if (o_result_ch !== 3'd0) begin n_err++; $display("FAIL reset_result_ch: got %0d want 0", o_result_ch); end
      n_cmp++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL reset_result_valid: got %b want 0", o_result_valid); end
      n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
      i_rst = 1'b0;
   endtask

   task automatic test_single();
      i_ch_req = 5'b00100;          // cycle 0
      tick();                       // cycle 1
      i_ch_req = '0;
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_c1: got %b want 0", o_busy); end
      tick();                       // cycle 2
      n_cmp++; if (o_logical_ch !== 3'd2) begin n_err++; $display("FAIL single_ch_c2: got %0d want 2", o_logical_ch); end
      n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL single_busy_c2: got %b want 1", o_busy); end
      repeat (3) tick();            // cycle 5
      n_cmp++; if (o_ch_start !== 1'b0) begin n_err++; $display("FAIL single_start_c5: got %b want 0", o_ch_start); end
      tick();                       // cycle 6
      n_cmp++; if (o_ch_start !== 1'b1) begin n_err++; $display("FAIL single_start_c6: got %b want 1", o_ch_start); end
      finish_ch(1, 7'h2A);
      n_cmp++; if (o_result_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", o_result_valid); end
      n_cmp++; if (o_result !== 7'h2A) begin n_err++; $display("FAIL single_result: got %h want 2a", o_result); end
      n_cmp++; if (o_result_ch !== 3'd2) begin n_err++; $display("FAIL single_result_ch: got %0d want 2", o_result_ch); end
      tick();
      n_cmp++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_pulse: got %b want 0", o_result_valid); end
      n_cmp++; if (o_result !== 7'h2A) begin n_err++; $display("FAIL single_result_hold: got %h want 2a", o_result); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", o_busy); end
   endtask

   task automatic test_fairness();
      bit ok;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      i_ch_req = 5'b11111;
      tick();
      i_ch_req = '0;
      for (int k = 0; k < c_N_CH; k++) begin
         wait_start(30, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL fair_start_%0d: got none want start", k); end
         n_cmp++; if (o_logical_ch !== 3'(k)) begin n_err++; $display("FAIL fair_order_%0d: got %0d want %0d", k, o_logical_ch, k); end
         finish_ch(3, 7'(7'h10 + k));
         n_cmp++; if (o_result_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid_%0d: got %b want 1", k, o_result_valid); end
         n_cmp++; if (o_result_ch !== 3'(k)) begin n_err++; $display("FAIL fair_result_ch_%0d: got %0d want %0d", k, o_result_ch, k); end
      end
      // Pointer must be back at 0: channel 0 wins over channel 4.
      i_ch_req = 5'b10001;
      tick();
      i_ch_req = '0;
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd0) begin n_err++; $display("FAIL fair_ptr_wrap: got ok=%b ch=%0d want ch=0", ok, o_logical_ch); end
      finish_ch(2, 7'h55);
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd4) begin n_err++; $display("FAIL fair_second: got ok=%b ch=%0d want ch=4", ok, o_logical_ch); end
      finish_ch(2, 7'h66);
      n_cmp++; if (o_result !== 7'h66) begin n_err++; $display("FAIL fair_result_last: got %h want 66", o_result); end
   endtask

   task automatic test_timeout();
      bit ok;
      bit saw_v;
      int got;
      saw_v = 1'b0;
      got   = -1;
      i_ch_req = 5'b01000;
      tick();
      i_ch_req = '0;
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd3) begin n_err++; $display("FAIL tmo_start: got ok=%b ch=%0d want ch=3", ok, o_logical_ch); end
      for (int i = 1; i <= c_TMO + 5; i++) begin
         tick();
         if (o_result_valid === 1'b1) saw_v = 1'b1;
         if (o_timeout === 1'b1) begin
            got = i;
            break;
         end
      end
      n_cmp++; if (got != c_TMO) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", got, c_TMO); end
      tick();
      n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_pulse_width: got %b want 0", o_timeout); end
      n_cmp++; if (saw_v || o_result_valid !== 1'b0) begin n_err++; $display("FAIL tmo_no_result: got %b want 0", saw_v | o_result_valid); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle: got %b want 0", o_busy); end
      i_ch_req = 5'b10001;
      tick();
      i_ch_req = '0;
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd4) begin n_err++; $display("FAIL tmo_next_ptr: got ok=%b ch=%0d want ch=4", ok, o_logical_ch); end
      finish_ch(1, 7'h44);
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd0) begin n_err++; $display("FAIL tmo_wrap: got ok=%b ch=%0d want ch=0", ok, o_logical_ch); end
      finish_ch(1, 7'h01);
   endtask

   task automatic test_rerequest();
      bit ok;
      i_ch_req = 5'b00010;
      tick();
      i_ch_req = '0;
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd1) begin n_err++; $display("FAIL rereq_first: got ok=%b ch=%0d want ch=1", ok, o_logical_ch); end
      i_ch_req = 5'b00010;          // during START
      tick();
      i_ch_req = '0;
      finish_ch(2, 7'h11);
      n_cmp++; if (o_result_valid !== 1'b1 || o_result !== 7'h11) begin n_err++; $display("FAIL rereq_result1: got v=%b r=%h want v=1 r=11", o_result_valid, o_result); end
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd1) begin n_err++; $display("FAIL rereq_second: got ok=%b ch=%0d want ch=1", ok, o_logical_ch); end
      finish_ch(1, 7'h12);
      n_cmp++; if (o_result !== 7'h12 || o_result_ch !== 3'd1) begin n_err++; $display("FAIL rereq_result2: got r=%h ch=%0d want r=12 ch=1", o_result, o_result_ch); end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      bit bad;
      bad = 1'b0;
      i_ch_req = 5'b00001;
      tick();
      i_ch_req = '0;
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd0) begin n_err++; $display("FAIL rstw_start: got ok=%b ch=%0d want ch=0", ok, o_logical_ch); end
      tick();
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      n_cmp++; if (o_busy !== 1'b0 || o_ch_start !== 1'b0 || o_logical_ch !== 3'd0) begin n_err++; $display("FAIL rstw_ctrl: got busy=%b start=%b ch=%0d want 0 0 0", o_busy, o_ch_start, o_logical_ch); end
      n_cmp++; if (o_result !== 7'h00 || o_result_ch !== 3'd0) begin n_err++; $display("FAIL rstw_result: got r=%h ch=%0d want 00 0", o_result, o_result_ch); end
      n_cmp++; if (o_result_valid !== 1'b0 || o_timeout !== 1'b0) begin n_err++; $display("FAIL rstw_pulses: got v=%b t=%b want 0 0", o_result_valid, o_timeout); end
      i_ch_adce_done = 1'b1;
      tick();
      i_ch_adce_done = 1'b0;
      for (int i = 0; i < 2 * c_TMO; i++) begin
         tick();
         if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_timeout !== 1'b0 || o_ch_start !== 1'b0) bad = 1'b1;
      end
      n_cmp++; if (bad) begin n_err++; $display("FAIL rstw_quiet: got activity=1 want 0"); end
   endtask

   task automatic test_enable_done();
      bit ok;
      bit bad;
      bad = 1'b0;
      i_enable = 1'b0;
      i_ch_req = 5'b00001;
      tick();
      i_ch_req = '0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (o_ch_start !== 1'b0 || o_busy !== 1'b0) bad = 1'b1;
      end
      n_cmp++; if (bad) begin n_err++; $display("FAIL en_blocked: got grant=1 want 0"); end
      i_enable = 1'b1;
      wait_start(30, ok);
      n_cmp++; if (!ok || o_logical_ch !== 3'd0) begin n_err++; $display("FAIL en_grant: got ok=%b ch=%0d want ch=0", ok, o_logical_ch); end
      i_enable = 1'b0;              // in-flight channel must still complete
      bad = 1'b0;
      for (int i = 1; i < c_TMO; i++) begin
         tick();
         if (o_timeout !== 1'b0 || o_result_valid !== 1'b0) bad = 1'b1;
      end
      n_cmp++; if (bad) begin n_err++; $display("FAIL coin_early: got early pulse=1 want 0"); end
      tick();                       // last WAIT cycle: timer expiring
      i_ch_adce_done = 1'b1;
      i_ch_testbus   = 7'h3C;
      #1;
      n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL coin_timeout: got %b want 0", o_timeout); end
      tick();
      i_ch_adce_done = 1'b0;
      n_cmp++; if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin n_err++; $display("FAIL coin_capture: got t=%b busy=%b want 0 1", o_timeout, o_busy); end
      tick();
      n_cmp++; if (o_result_valid !== 1'b1 || o_result !== 7'h3C) begin n_err++; $display("FAIL coin_result: got v=%b r=%h want 1 3c", o_result_valid, o_result); end
      n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL coin_timeout_after: got %b want 0", o_timeout); end
      i_enable = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_rerequest();
      test_reset_mid_wait();
      test_enable_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
